// File: rtl/fifo_1r1w_rolly_pkg.sv
// Shared types for the rollback FIFO slice.
//   rd_op_e : read-pointer update selected each cycle by the pointer tracker.
package fifo_1r1w_rolly_pkg;

  typedef enum logic [1:0] {
    RD_STEP    = 2'd0,  // rptr advances by the speculative dequeue (or holds)
    RD_REWIND  = 2'd1,  // rptr returns to the committed pointer
    RD_FORWARD = 2'd2,  // committed pointer catches up with the stepped rptr
    RD_CLEAR   = 2'd3   // both read pointers jump to the write pointer
  } rd_op_e;

endpackage

// File: rtl/fifo_rolly_ptr_tracker.sv
// Pointer bookkeeping for fifo_1r1w_rolly.
// Holds the write pointer, the speculative read pointer and the committed
// read pointer (each lg_size_p+1 bits, MSB is the wrap bit) and derives
// full/empty from them.
// Ports:
//   clk_i, reset_i   : clock, asynchronous active-high reset
//   clr_i            : discard all entries (read pointers jump to wptr)
//   incr_w_i         : accepted enqueue, advances wptr
//   incr_r_i         : speculative dequeue, advances rptr
//   rewind_i         : rptr returns to rcptr
//   forward_i        : rcptr (and rptr) move to the stepped rptr
//   waddr_o, raddr_o : storage indices for write / speculative read
//   full_o, empty_o  : occupancy flags, from registered pointers only
module fifo_rolly_ptr_tracker
  import fifo_1r1w_rolly_pkg::*;
#(
  parameter int unsigned lg_size_p = 2
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clr_i,
  input  logic                 incr_w_i,
  input  logic                 incr_r_i,
  input  logic                 rewind_i,
  input  logic                 forward_i,
  output logic [lg_size_p-1:0] waddr_o,
  output logic [lg_size_p-1:0] raddr_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned ptr_w = lg_size_p + 1;
  localparam logic [ptr_w-1:0] size_lp = ptr_w'(1) << lg_size_p;

  logic [ptr_w-1:0] wptr;
  logic [ptr_w-1:0] rptr;
  logic [ptr_w-1:0] rcptr;
  logic [ptr_w-1:0] rptr_n;
  logic [ptr_w-1:0] used;
  rd_op_e           rd_op;

  assign rptr_n = rptr + ptr_w'(incr_r_i);

  // Forward wins over rewind: deq then roll lands on the freshly committed
  // point, which is the same as a plain commit.
  always_comb begin
    rd_op = RD_STEP;
    if (clr_i)          rd_op = RD_CLEAR;
    else if (forward_i) rd_op = RD_FORWARD;
    else if (rewind_i)  rd_op = RD_REWIND;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr  <= '0;
      rptr  <= '0;
      rcptr <= '0;
    end else begin
      wptr <= wptr + ptr_w'(incr_w_i);
      unique case (rd_op)
        RD_CLEAR: begin
          rptr  <= wptr;
          rcptr <= wptr;
        end
        RD_FORWARD: begin
          rptr  <= rptr_n;
          rcptr <= rptr_n;
        end
        RD_REWIND: rptr <= rcptr;
        default:   rptr <= rptr_n;
      endcase
    end
  end

  // Capacity is measured from the committed pointer: speculatively read
  // entries still hold their slots until committed.
  assign used    = wptr - rcptr;
  assign full_o  = (used == size_lp);
  assign empty_o = (rptr == wptr);
  assign waddr_o = wptr[lg_size_p-1:0];
  assign raddr_o = rptr[lg_size_p-1:0];

endmodule

// File: rtl/fifo_1r1w_rolly.sv
// Single-clock 1R1W FIFO with a rollback-capable read side.
// The consumer dequeues speculatively (yumi_i), then commits (deq_v_i) or
// replays (roll_v_i) those entries; clr_v_i discards everything queued.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clr_v_i        : drop all entries present at the start of the cycle
//   deq_v_i        : commit all speculative dequeues
//   roll_v_i       : rewind the read pointer to the last commit point
//   data_i, v_i    : enqueue data / valid
//   ready_o        : enqueue ready (~full)
//   data_o, v_o    : head entry at the speculative read pointer / ~empty
//   yumi_i         : speculative dequeue, legal only while v_o=1
module fifo_1r1w_rolly #(
  parameter int unsigned width_p   = 32,
  parameter int unsigned lg_size_p = 2,
  parameter int unsigned harden_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_v_i,
  input  logic               deq_v_i,
  input  logic               roll_v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int unsigned els_lp = 1 << lg_size_p;

  logic                 full;
  logic                 empty;
  logic                 enq;
  logic [lg_size_p-1:0] waddr;
  logic [lg_size_p-1:0] raddr;

  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign enq     = v_i & ~full;

  fifo_rolly_ptr_tracker #(
    .lg_size_p(lg_size_p)
  ) ptr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (clr_v_i),
    .incr_w_i (enq),
    .incr_r_i (yumi_i),
    .rewind_i (roll_v_i),
    .forward_i(deq_v_i),
    .waddr_o  (waddr),
    .raddr_o  (raddr),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Both branches share the block name and the array name so hierarchical
  // references resolve identically whichever storage is selected.
  if (harden_p != 0) begin : storage
    // 1r1w memory wrapper: synchronous write port, asynchronous read port.
    logic [width_p-1:0] mem [els_lp];

    always_ff @(posedge clk_i) begin
      if (enq) mem[waddr] <= data_i;
    end

    assign data_o = mem[raddr];
  end else begin : storage
    // Flop array: one enable per entry decoded from the write index.
    logic [width_p-1:0] mem [els_lp];

    always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < els_lp; i++) begin
        if (enq && (waddr == lg_size_p'(i))) mem[i] <= data_i;
      end
    end

    assign data_o = mem[raddr];
  end

endmodule

// File: tb/tb_fifo_1r1w_rolly.sv
module tb_fifo_1r1w_rolly;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_v, deq_v, roll_v, v_in, yumi;
  logic [31:0] din;
  logic        rdy_h, v_h, rdy_f, v_f;
  logic [31:0] d_h, d_f;

  always #5 clk = ~clk;

  fifo_1r1w_rolly #(.width_p(32), .lg_size_p(2), .harden_p(1)) dut_h (
    .clk_i(clk), .reset_i(rst), .clr_v_i(clr_v), .deq_v_i(deq_v),
    .roll_v_i(roll_v), .data_i(din), .v_i(v_in), .ready_o(rdy_h),
    .data_o(d_h), .v_o(v_h), .yumi_i(yumi)
  );

  fifo_1r1w_rolly #(.width_p(32), .lg_size_p(2), .harden_p(0)) dut_f (
    .clk_i(clk), .reset_i(rst), .clr_v_i(clr_v), .deq_v_i(deq_v),
    .roll_v_i(roll_v), .data_i(din), .v_i(v_in), .ready_o(rdy_f),
    .data_o(d_f), .v_o(v_f), .yumi_i(yumi)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: all entries from the commit point onward, plus the
  // number of them that have been speculatively read.
  logic [31:0] mq[$];
  int          spec = 0;

  typedef struct {
    logic        v;
    logic        rdy;
    logic [31:0] d;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        y, dq, rl, cl;
    logic        ev, er;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl[38];

  function automatic vec_t mk(logic v, logic [31:0] d, logic y, logic dq,
                              logic rl, logic cl, logic ev, logic er,
                              logic [31:0] ed);
    vec_t r;
    r.v = v; r.d = d; r.y = y; r.dq = dq; r.rl = rl; r.cl = cl;
    r.ev = ev; r.er = er; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.v   = (spec < mq.size());
    e.rdy = (mq.size() < 4);
    e.d   = e.v ? mq[spec] : 32'h0;
    return e;
  endfunction

  // Called on a negedge: drive, advance model, push expectation, clock,
  // then pop and compare both instances. Returns on the next negedge.
  task automatic cyc(input logic v, input logic [31:0] d, input logic y,
                     input logic dq, input logic rl, input logic cl);
    logic enq_ok;
    exp_t e;
    v_in = v; din = d; yumi = y; deq_v = dq; roll_v = rl; clr_v = cl;
    enq_ok = v && (mq.size() < 4);
    if (cl) begin
      mq.delete();
      spec = 0;
    end else if (dq) begin
      repeat (spec + int'(y)) void'(mq.pop_front());
      spec = 0;
    end else if (rl) begin
      spec = 0;
    end else begin
      spec += int'(y);
    end
    if (enq_ok) mq.push_back(d);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("v_o_h", 32'(v_h), 32'(e.v));
    chk("ready_o_h", 32'(rdy_h), 32'(e.rdy));
    chk("v_o_f", 32'(v_f), 32'(e.v));
    chk("ready_o_f", 32'(rdy_f), 32'(e.rdy));
    if (e.v) begin
      chk("data_o_h", d_h, e.d);
      chk("data_o_f", d_f, e.d);
    end
    @(negedge clk);
    v_in = 0; yumi = 0; deq_v = 0; roll_v = 0; clr_v = 0;
  endtask

  initial begin
    rst = 1; clr_v = 0; deq_v = 0; roll_v = 0; v_in = 0; yumi = 0; din = '0;

    // fill/drain, full-write ignored, commit frees space
    tbl[0]  = mk(1, 32'hA0, 0,0,0,0, 1,1, 32'hA0);
    tbl[1]  = mk(1, 32'hA1, 0,0,0,0, 1,1, 32'hA0);
    tbl[2]  = mk(1, 32'hA2, 0,0,0,0, 1,1, 32'hA0);
    tbl[3]  = mk(1, 32'hA3, 0,0,0,0, 1,0, 32'hA0);
    tbl[4]  = mk(0, 32'h0,  1,0,0,0, 1,0, 32'hA1);
    tbl[5]  = mk(0, 32'h0,  1,0,0,0, 1,0, 32'hA2);
    tbl[6]  = mk(0, 32'h0,  1,0,0,0, 1,0, 32'hA3);
    tbl[7]  = mk(0, 32'h0,  1,0,0,0, 0,0, 32'h0);
    tbl[8]  = mk(0, 32'h0,  0,0,0,0, 0,0, 32'h0);
    tbl[9]  = mk(1, 32'hB0, 0,0,0,0, 0,0, 32'h0);
    tbl[10] = mk(0, 32'h0,  0,1,0,0, 0,1, 32'h0);
    // rollback
    tbl[11] = mk(1, 32'h10, 0,0,0,0, 1,1, 32'h10);
    tbl[12] = mk(1, 32'h11, 0,0,0,0, 1,1, 32'h10);
    tbl[13] = mk(1, 32'h12, 0,0,0,0, 1,1, 32'h10);
    tbl[14] = mk(0, 32'h0,  1,0,0,0, 1,1, 32'h11);
    tbl[15] = mk(0, 32'h0,  1,0,0,0, 1,1, 32'h12);
    tbl[16] = mk(0, 32'h0,  0,0,1,0, 1,1, 32'h10);
    tbl[17] = mk(0, 32'h0,  1,0,0,0, 1,1, 32'h11);
    tbl[18] = mk(0, 32'h0,  1,0,0,0, 1,1, 32'h12);
    tbl[19] = mk(0, 32'h0,  0,1,0,0, 1,1, 32'h12);
    tbl[20] = mk(0, 32'h0,  0,0,1,0, 1,1, 32'h12);
    tbl[21] = mk(0, 32'h0,  1,1,0,0, 0,1, 32'h0);
    // clear with same-cycle enqueue
    tbl[22] = mk(1, 32'hC0, 0,0,0,0, 1,1, 32'hC0);
    tbl[23] = mk(1, 32'hC1, 0,0,0,0, 1,1, 32'hC0);
    tbl[24] = mk(1, 32'hC2, 0,0,0,0, 1,1, 32'hC0);
    tbl[25] = mk(1, 32'hC3, 0,0,0,0, 1,0, 32'hC0);
    tbl[26] = mk(0, 32'h0,  1,0,0,0, 1,0, 32'hC1);
    tbl[27] = mk(0, 32'h0,  1,1,0,0, 1,1, 32'hC2);
    tbl[28] = mk(1, 32'h55, 0,0,0,1, 1,1, 32'h55);
    tbl[29] = mk(1, 32'hD1, 0,0,0,0, 1,1, 32'h55);
    tbl[30] = mk(1, 32'hD2, 0,0,0,0, 1,1, 32'h55);
    tbl[31] = mk(1, 32'hD3, 0,0,0,0, 1,0, 32'h55);
    // deq+roll+yumi together commits exactly one entry
    tbl[32] = mk(0, 32'h0,  1,1,0,0, 1,1, 32'hD1);
    tbl[33] = mk(0, 32'h0,  1,1,1,0, 1,1, 32'hD2);
    tbl[34] = mk(0, 32'h0,  0,0,1,0, 1,1, 32'hD2);
    tbl[35] = mk(1, 32'hE0, 0,0,0,0, 1,1, 32'hD2);
    tbl[36] = mk(1, 32'hE1, 0,0,0,0, 1,0, 32'hD2);
    // clear overrides yumi/deq
    tbl[37] = mk(0, 32'h0,  1,1,0,1, 0,1, 32'h0);

    repeat (2) @(negedge clk);
    chk("reset_v_o", 32'(v_h), 32'h0);
    chk("reset_ready_o", 32'(rdy_h), 32'h1);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 38; i++) begin
      cyc(tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].dq, tbl[i].rl, tbl[i].cl);
      chk($sformatf("vec%0d_v", i), 32'(v_h), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_ready", i), 32'(rdy_h), 32'(tbl[i].er));
      if (tbl[i].ev) chk($sformatf("vec%0d_data", i), d_h, tbl[i].ed);
    end

    // random stress across many pointer wraps
    for (int i = 0; i < 300; i++) begin
      logic y;
      y = (spec < mq.size()) && ($urandom_range(0, 1) == 1);
      cyc($urandom_range(0, 3) != 0, $urandom, y,
          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 28) == 0);
    end

    // asynchronous reset while three entries are held
    cyc(0, 32'h0, 0, 0, 0, 1);
    cyc(1, 32'hF0, 0, 0, 0, 0);
    cyc(1, 32'hF1, 0, 0, 0, 0);
    cyc(1, 32'hF2, 0, 0, 0, 0);
    #2;
    rst = 1;
    #1;
    chk("async_reset_v_o_h", 32'(v_h), 32'h0);
    chk("async_reset_ready_o_h", 32'(rdy_h), 32'h1);
    chk("async_reset_v_o_f", 32'(v_f), 32'h0);
    chk("async_reset_ready_o_f", 32'(rdy_f), 32'h1);
    mq.delete();
    spec = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    cyc(1, 32'h77, 0, 0, 0, 0);
    cyc(0, 32'h0, 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
